// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor, LSB first, one bit per clock.
// Result, carry and signed overflow are held until the next operation completes.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             IN_CLK,
   input  logic             IN_RST,
   input  logic             IN_START,
   input  logic             IN_SUB,
   input  logic [WIDTH-1:0] IN_A,
   input  logic [WIDTH-1:0] IN_B,
   input  logic             IN_CIN,
   output logic [WIDTH-1:0] O_SUM,
   output logic             O_COUT,
   output logic             O_OVF,
   output logic             O_BUSY,
   output logic             O_DONE
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_res;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;

   logic w_accept;
   logic w_last;
   logic w_hs1_s;
   logic w_hs1_c;
   logic w_hs2_c;
   logic w_s;
   logic w_c;

   // Full adder from two half-adder stages.
   assign w_hs1_s = r_a[0] ^ r_b[0];
   assign w_hs1_c = r_a[0] & r_b[0];
   assign w_s     = w_hs1_s ^ r_carry;
   assign w_hs2_c = w_hs1_s & r_carry;
   assign w_c     = w_hs1_c | w_hs2_c;

   assign w_accept = IN_START && (r_state != S_SHIFT);
   assign w_last   = (r_state == S_SHIFT) && (r_cnt == LAST);

   assign O_BUSY = (r_state == S_SHIFT);
   assign O_DONE = (r_state == S_DONE);

   always_ff @(posedge IN_CLK or posedge IN_RST) begin
      if (IN_RST) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (IN_START) w_next = S_SHIFT;
         end
         S_SHIFT: begin
            if (r_cnt == LAST) w_next = S_DONE;
         end
         S_DONE: begin
            w_next = IN_START ? S_SHIFT : S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge IN_CLK or posedge IN_RST) begin
      if (IN_RST) begin
         r_a     <= '0;
         r_b     <= '0;
         r_res   <= '0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
         O_SUM   <= '0;
         O_COUT  <= 1'b0;
         O_OVF   <= 1'b0;
      end else if (w_accept) begin
         r_a     <= IN_A;
         r_b     <= IN_SUB ? ~IN_B : IN_B;
         r_carry <= IN_SUB ? 1'b1 : IN_CIN;
         r_cnt   <= '0;
      end else if (r_state == S_SHIFT) begin
         r_a     <= r_a >> 1;
         r_b     <= r_b >> 1;
         r_res   <= {w_s, r_res[WIDTH-1:1]};
         r_carry <= w_c;
         r_cnt   <= r_cnt + 1'b1;
         // On the last bit r_carry is the carry into the MSB.
         if (w_last) begin
            O_SUM  <= {w_s, r_res[WIDTH-1:1]};
            O_COUT <= w_c;
            O_OVF  <= r_carry ^ w_c;
         end
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=2.
// Reference model uses plain integer arithmetic on the operands.
module tb_serial_adder;

   logic       clk = 1'b0;
   logic       rst;

   logic       st8, sub8, cin8;
   logic [7:0] a8, b8, sum8;
   logic       co8, ov8, bz8, dn8;

   logic       st2, sub2, cin2;
   logic [1:0] a2, b2, sum2;
   logic       co2, ov2, bz2, dn2;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [9:0] prev8;
   logic [9:0] prev2;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(8)) u8 (
      .IN_CLK(clk), .IN_RST(rst), .IN_START(st8), .IN_SUB(sub8),
      .IN_A(a8), .IN_B(b8), .IN_CIN(cin8),
      .O_SUM(sum8), .O_COUT(co8), .O_OVF(ov8),
      .O_BUSY(bz8), .O_DONE(dn8)
   );

   serial_adder #(.WIDTH(2)) u2 (
      .IN_CLK(clk), .IN_RST(rst), .IN_START(st2), .IN_SUB(sub2),
      .IN_A(a2), .IN_B(b2), .IN_CIN(cin2),
      .O_SUM(sum2), .O_COUT(co2), .O_OVF(ov2),
      .O_BUSY(bz2), .O_DONE(dn2)
   );

   task automatic chk(input string tag, input logic [31:0] o,
                      input logic [31:0] e);
      n_cmp++;
      assert (o === e) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   // Returns {ovf, cout, sum} from integer arithmetic.
   function automatic logic [9:0] model(input int w, input int a,
                                        input int b, input bit cin,
                                        input bit sub);
      int mask, bb, t, s;
      bit co, sa, sb, ss, ov;
      logic [7:0] s8;
      mask = (1 << w) - 1;
      bb   = sub ? (~b & mask) : (b & mask);
      t    = (a & mask) + bb + (sub ? 1 : int'(cin));
      s    = t & mask;
      co   = bit'((t >> w) & 1);
      sa   = bit'((a >> (w - 1)) & 1);
      sb   = bit'((bb >> (w - 1)) & 1);
      ss   = bit'((s >> (w - 1)) & 1);
      ov   = (sa == sb) && (ss != sa);
      s8   = s[7:0];
      return {ov, co, s8};
   endfunction

   function automatic logic [9:0] obs(input int w);
      if (w == 2) return {ov2, co2, 6'b0, sum2};
      return {ov8, co8, sum8};
   endfunction

   function automatic logic busy(input int w);
      return (w == 2) ? bz2 : bz8;
   endfunction

   function automatic logic done(input int w);
      return (w == 2) ? dn2 : dn8;
   endfunction

   task automatic drive(input int w, input logic st, input logic [7:0] a,
                        input logic [7:0] b, input logic cin,
                        input logic sub);
      if (w == 2) begin
         st2 = st; a2 = a[1:0]; b2 = b[1:0]; cin2 = cin; sub2 = sub;
      end else begin
         st8 = st; a8 = a; b8 = b; cin8 = cin; sub8 = sub;
      end
   endtask

   // Called #1 after an edge; returns #1 after the edge showing O_DONE.
   task automatic do_op(input string tag, input int w, input logic [7:0] a,
                        input logic [7:0] b, input logic cin,
                        input logic sub, input int pulse_at);
      logic [9:0] e, p;
      int lat;
      e   = model(w, int'(a), int'(b), cin, sub);
      p   = (w == 2) ? prev2 : prev8;
      lat = -1;
      drive(w, 1'b1, a, b, cin, sub);
      @(posedge clk); #1;
      drive(w, 1'b0, ~a, ~b, ~cin, ~sub);
      chk({tag, ".busy_on_accept"}, 32'(busy(w)), 32'd1);
      chk({tag, ".done_low_accept"}, 32'(done(w)), 32'd0);
      for (int i = 1; i <= 3 * w; i++) begin
         @(posedge clk); #1;
         if (done(w)) begin
            lat = i;
            break;
         end
         chk({tag, ".hold"}, 32'(obs(w)), 32'(p));
         chk({tag, ".busy"}, 32'(busy(w)), 32'd1);
         if (i == pulse_at) drive(w, 1'b1, ~a, b ^ 8'h55, 1'b1, ~sub);
         else drive(w, 1'b0, a ^ 8'hA5, b, cin, sub);
      end
      drive(w, 1'b0, a, b, cin, sub);
      chk({tag, ".latency"}, 32'(lat), 32'(w));
      chk({tag, ".result"}, 32'(obs(w)), 32'(e));
      chk({tag, ".busy_at_done"}, 32'(busy(w)), 32'd0);
      if (w == 2) prev2 = e;
      else prev8 = e;
   endtask

   task automatic idle(input int w);
      @(posedge clk); #1;
      chk("idle.done", 32'(done(w)), 32'd0);
      chk("idle.busy", 32'(busy(w)), 32'd0);
      chk("idle.hold", 32'(obs(w)), 32'((w == 2) ? prev2 : prev8));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      drive(8, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
      drive(2, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
      prev8 = '0;
      prev2 = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst.out8", 32'(obs(8)), 32'd0);
      chk("rst.busy8", 32'(bz8), 32'd0);
      chk("rst.done8", 32'(dn8), 32'd0);
      chk("rst.out2", 32'(obs(2)), 32'd0);
      rst = 1'b0;
      drive(8, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      drive(2, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      @(posedge clk); #1;
      chk("rel.busy8", 32'(bz8), 32'd0);
      chk("rel.done8", 32'(dn8), 32'd0);

      do_op("add5a3c", 8, 8'h5A, 8'h3C, 1'b0, 1'b0, 0);
      chk("add5a3c.const", 32'(obs(8)), 32'h296);
      idle(8);
      do_op("addff01", 8, 8'hFF, 8'h01, 1'b0, 1'b0, 0);
      chk("addff01.const", 32'(obs(8)), 32'h100);
      idle(8);
      do_op("sub1020", 8, 8'h10, 8'h20, 1'b0, 1'b1, 0);
      chk("sub1020.const", 32'(obs(8)), 32'h0F0);
      idle(8);
      do_op("sub8001", 8, 8'h80, 8'h01, 1'b0, 1'b1, 0);
      chk("sub8001.const", 32'(obs(8)), 32'h37F);
      idle(8);

      do_op("midshift", 8, 8'h12, 8'h34, 1'b1, 1'b0, 3);
      idle(8);

      do_op("b2b_1", 8, 8'hC3, 8'h7E, 1'b1, 1'b0, 0);
      do_op("b2b_2", 8, 8'h41, 8'h99, 1'b0, 1'b1, 0);
      idle(8);

      drive(8, 1'b1, 8'h77, 8'h11, 1'b0, 1'b0);
      @(posedge clk); #1;
      drive(8, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("midrst.out", 32'(obs(8)), 32'd0);
      chk("midrst.busy", 32'(bz8), 32'd0);
      chk("midrst.done", 32'(dn8), 32'd0);
      #2;
      rst = 1'b0;
      prev8 = '0;
      prev2 = '0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         chk("midrst.quiet", 32'({dn8, bz8}), 32'd0);
      end

      for (int i = 0; i < 20; i++) begin
         do_op("rand8", 8, 8'($urandom), 8'($urandom),
               1'($urandom), 1'($urandom), 0);
         if ($urandom_range(0, 1) == 1) idle(8);
      end

      for (int a = 0; a < 4; a++)
         for (int b = 0; b < 4; b++)
            for (int c = 0; c < 2; c++)
               for (int s = 0; s < 2; s++) begin
                  do_op("exh2", 2, 8'(a), 8'(b), 1'(c), 1'(s), 0);
                  idle(2);
               end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_fail);
      $finish;
   end

endmodule
